vector_response_checker: RTL and testbench
==========================================

Name: vector_response_checker

Overview:
- Hardware counterpart to our vector-driven benches: accepts a stream of expected-output vectors, waits a programmable settle time, samples the DUT output and compares.
- Counts vectors and mismatches and captures the index of the first failure.
- Sits beside a DUT (e.g. the T flip-flop variants) in self-checking FPGA/sim harnesses, replacing file-based checking.

Parameters:
WIDTH, 1, bit width of compared DUT output.
CNTW, 32, width of vector/error counters and first-error index.
SETTLE, 1, clk cycles between vector acceptance and sampling of dut_q (0 allowed).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  begin a run; clears counters (honoured in IDLE and DONE only)
vec_valid  input  1  expected vector present
vec_ready  output  1  checker can accept a vector
vec_expected  input  WIDTH  expected dut_q value
vec_mask  input  WIDTH  1 = don't-care bit, excluded from compare
vec_last  input  1  marks final vector of the run
dut_q  input  WIDTH  DUT output under check
vector_count  output  CNTW  vectors compared this run
error_count  output  CNTW  vectors with at least one mismatching unmasked bit
first_err_seen  output  1  a mismatch has occurred this run
first_err_index  output  CNTW  vector_count value (0-based) of first failing vector
mismatch  output  1  one-cycle pulse, cycle after a failing compare
busy  output  1  high in WAIT_VEC, SETTLE, COMPARE
done  output  1  high in DONE

Behaviour:
- Reset (async, active-high): state IDLE; all counters, first_err_index, first_err_seen, mismatch, busy, done, vec_ready = 0; captured registers = 0.
- States: IDLE, WAIT_VEC, SETTLE, COMPARE, DONE.
- IDLE: start=1 -> WAIT_VEC; same edge clears vector_count, error_count, first_err_seen, first_err_index.
- WAIT_VEC: vec_ready=1 (combinational from state). Transfer when vec_valid & vec_ready at a rising edge: capture expected, mask and last; load settle counter with SETTLE; go to SETTLE if SETTLE>0, else COMPARE. vec_valid low: remain, no timeout.
- SETTLE: decrement each cycle; when the counter reaches 1, go to COMPARE. Residence in SETTLE is exactly SETTLE cycles.
- COMPARE: one cycle.
  - fail = |((dut_q ^ exp) & ~mask), evaluated on dut_q in this cycle.
  - At the edge, vector_count increments.
  - If fail: error_count increments; if first_err_seen=0, set it and load first_err_index with the pre-increment vector_count.
  - mismatch = registered fail, so it is high for exactly the following cycle.
  - Next state is DONE if the captured last=1, else WAIT_VEC.
- Latency: acceptance edge to compare cycle = SETTLE+1 edges; minimum vector period = SETTLE+2 cycles.
- DONE: done=1 and counters held until start. start -> WAIT_VEC with counter clear, i.e. a new run.
- start while busy is ignored; counters are unaffected.
- Counters saturate at all-ones and never wrap. first_err_index does not change once set.
- All-ones mask: the vector always passes but is still counted.
- Reset mid-run aborts immediately to IDLE with all outputs cleared. A vector being presented is dropped; the upstream source must re-present it after reset.
- vec_ready is 0 in every state except WAIT_VEC. Upstream holds vec_valid and data stable until transfer.

Decomposition:
- Shared package vrc_pkg:
  - state enum (IDLE, WAIT_VEC, SETTLE, COMPARE, DONE);
  - saturating-increment function parameterised by width;
  - localparam for settle-counter width, clog2(SETTLE+1) with a minimum of 1.
- One natural sub-module, vrc_sat_counter: saturating counter with clear and enable. It is instantiated twice, for vector_count and error_count.

Test Plan:
- Reset during WAIT_VEC with vec_valid=1 -> next cycle all outputs 0, state IDLE, vec_ready=0; start then accepted normally.
- WIDTH=1, SETTLE=1; vectors exp 0,1,1,0 (last on 4th); dut_q matches -> vector_count=4, error_count=0, first_err_seen=0, done=1; each vector takes 3 cycles.
- Same stream, dut_q forced 0 throughout -> error_count=2, first_err_index=1, mismatch pulses twice, each 1 cycle wide.
- WIDTH=4, exp=4'b1010, mask=4'b0011, dut_q=4'b1001 -> pass. Same with mask=4'b0000 -> error_count=1.
- SETTLE=0, vec_valid held high continuously for 5 vectors -> one acceptance every 2 cycles, vector_count=5. start pulsed while busy -> no effect.
- CNTW=3, 10 failing vectors -> vector_count=7 and error_count=7 (saturated), first_err_index=0. Restart via start from DONE clears all counters to 0.

Source files
------------

// File: rtl/vrc_pkg.sv
// Shared types and helpers for the vector response checker: FSM states,
// saturating increment and settle-counter sizing.
package vrc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VEC,
    ST_SETTLE,
    ST_COMPARE,
    ST_DONE
  } vrc_state_e;

  // Widest counter the saturating helper supports.
  localparam int unsigned VRC_MAX_W = 64;

  // Settle counter must hold SETTLE itself; keep at least one bit when SETTLE is 0.
  function automatic int unsigned vrc_settle_width(input int unsigned settle);
    int unsigned w;
    w = $clog2(settle + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [VRC_MAX_W-1:0] vrc_sat_inc(
    input logic [VRC_MAX_W-1:0] value,
    input int unsigned          width
  );
    logic [VRC_MAX_W-1:0] ones;
    ones = {VRC_MAX_W{1'b1}} >> (VRC_MAX_W - width);
    return (value >= ones) ? value : value + VRC_MAX_W'(1);
  endfunction

endpackage

// File: rtl/vrc_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module vrc_sat_counter
  import vrc_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = W'(vrc_sat_inc(VRC_MAX_W'(count_q), W));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/vector_response_checker.sv
// Accepts expected-output vectors, waits SETTLE cycles, compares the DUT output
// under a don't-care mask and keeps run statistics plus the first failing index.
module vector_response_checker
  import vrc_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned CNTW   = 32,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [WIDTH-1:0] vec_expected,
  input  logic [WIDTH-1:0] vec_mask,
  input  logic             vec_last,
  input  logic [WIDTH-1:0] dut_q,
  output logic [CNTW-1:0]  vector_count,
  output logic [CNTW-1:0]  error_count,
  output logic             first_err_seen,
  output logic [CNTW-1:0]  first_err_index,
  output logic             mismatch,
  output logic             busy,
  output logic             done
);

  localparam int unsigned     SETW        = vrc_settle_width(SETTLE);
  localparam logic [SETW-1:0] SETTLE_LOAD = SETW'(SETTLE);
  localparam logic [SETW-1:0] SETTLE_ONE  = SETW'(1);

  vrc_state_e       state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             last_q, last_d;
  logic [SETW-1:0]  settle_q, settle_d;
  logic             seen_q, seen_d;
  logic [CNTW-1:0]  idx_q, idx_d;
  logic             mismatch_q, mismatch_d;

  logic run_start;
  logic cmp_en;
  logic fail;
  logic err_en;

  assign run_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign cmp_en    = (state_q == ST_COMPARE);
  assign fail      = |((dut_q ^ exp_q) & ~mask_q);
  assign err_en    = cmp_en && fail;

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    mask_d     = mask_q;
    last_d     = last_q;
    settle_d   = settle_q;
    seen_d     = seen_q;
    idx_d      = idx_q;
    mismatch_d = err_en;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WAIT_VEC;
          seen_d  = 1'b0;
          idx_d   = '0;
        end
      end
      ST_WAIT_VEC: begin
        if (vec_valid) begin
          exp_d    = vec_expected;
          mask_d   = vec_mask;
          last_d   = vec_last;
          settle_d = SETTLE_LOAD;
          state_d  = (SETTLE == 0) ? ST_COMPARE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // Leaving on a count of one gives exactly SETTLE cycles of residence.
        if (settle_q <= SETTLE_ONE) begin
          state_d = ST_COMPARE;
        end else begin
          settle_d = settle_q - SETTLE_ONE;
        end
      end
      ST_COMPARE: begin
        if (fail && !seen_q) begin
          seen_d = 1'b1;
          idx_d  = vector_count;
        end
        state_d = last_q ? ST_DONE : ST_WAIT_VEC;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      exp_q      <= '0;
      mask_q     <= '0;
      last_q     <= 1'b0;
      settle_q   <= '0;
      seen_q     <= 1'b0;
      idx_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      mask_q     <= mask_d;
      last_q     <= last_d;
      settle_q   <= settle_d;
      seen_q     <= seen_d;
      idx_q      <= idx_d;
      mismatch_q <= mismatch_d;
    end
  end

  vrc_sat_counter #(.W(CNTW)) u_vector_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (run_start),
    .en_i    (cmp_en),
    .count_o (vector_count)
  );

  vrc_sat_counter #(.W(CNTW)) u_error_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (run_start),
    .en_i    (err_en),
    .count_o (error_count)
  );

  assign vec_ready       = (state_q == ST_WAIT_VEC);
  assign busy            = (state_q == ST_WAIT_VEC) || (state_q == ST_SETTLE) || (state_q == ST_COMPARE);
  assign done            = (state_q == ST_DONE);
  assign mismatch        = mismatch_q;
  assign first_err_seen  = seen_q;
  assign first_err_index = idx_q;

endmodule

// File: tb/tb_vector_response_checker.sv
// Scoreboarded bench: instance A (4-bit, settle 1) runs directed and random
// streams; instance B (1-bit, settle 0, 3-bit counters) covers back-to-back and saturation.
`timescale 1ns/1ps
module tb_vector_response_checker;

  localparam int unsigned AW = 4, AS = 1, AC = 16;
  localparam int unsigned BW = 1, BS = 0, BC = 3;
  localparam int unsigned A_MAX = (1 << AC) - 1;
  localparam int unsigned B_MAX = (1 << BC) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic          a_start = 1'b0, a_vec_valid = 1'b0, a_vec_last = 1'b0, a_vec_ready;
  logic [AW-1:0] a_vec_expected = '0, a_vec_mask = '0, a_dut_q = '0;
  logic [AC-1:0] a_vector_count, a_error_count, a_first_err_index;
  logic          a_first_err_seen, a_mismatch, a_busy, a_done;

  logic          b_start = 1'b0, b_vec_valid = 1'b0, b_vec_last = 1'b0, b_vec_ready;
  logic [BW-1:0] b_vec_expected = '0, b_vec_mask = '0, b_dut_q = '0;
  logic [BC-1:0] b_vector_count, b_error_count, b_first_err_index;
  logic          b_first_err_seen, b_mismatch, b_busy, b_done;

  vector_response_checker #(.WIDTH(AW), .CNTW(AC), .SETTLE(AS)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .vec_valid(a_vec_valid), .vec_ready(a_vec_ready),
    .vec_expected(a_vec_expected), .vec_mask(a_vec_mask), .vec_last(a_vec_last), .dut_q(a_dut_q),
    .vector_count(a_vector_count), .error_count(a_error_count), .first_err_seen(a_first_err_seen),
    .first_err_index(a_first_err_index), .mismatch(a_mismatch), .busy(a_busy), .done(a_done)
  );

  vector_response_checker #(.WIDTH(BW), .CNTW(BC), .SETTLE(BS)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .vec_valid(b_vec_valid), .vec_ready(b_vec_ready),
    .vec_expected(b_vec_expected), .vec_mask(b_vec_mask), .vec_last(b_vec_last), .dut_q(b_dut_q),
    .vector_count(b_vector_count), .error_count(b_error_count), .first_err_seen(b_first_err_seen),
    .first_err_index(b_first_err_index), .mismatch(b_mismatch), .busy(b_busy), .done(b_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference model of run statistics for instance A.
  int unsigned m_vc, m_ec, m_idx;
  bit          m_seen;

  typedef struct {
    bit          mm;
    int unsigned vc;
    int unsigned ec;
    bit          seen;
    int unsigned idx;
  } exp_t;
  exp_t sb_q[$];

  function automatic bit ref_fail(input logic [AW-1:0] e, input logic [AW-1:0] m, input logic [AW-1:0] d);
    for (int i = 0; i < int'(AW); i++) begin
      if (!m[i] && (e[i] != d[i])) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic pulse_start_a();
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    m_vc = 0; m_ec = 0; m_idx = 0; m_seen = 1'b0;
  endtask

  task automatic send_a(input logic [AW-1:0] e, input logic [AW-1:0] m, input logic [AW-1:0] d,
                        input bit last, input int gap, input bit poke, output time t_acc);
    int   n;
    bit   f;
    exp_t x;
    repeat (gap) begin @(posedge clk); #1; end
    a_vec_valid = 1'b1; a_vec_expected = e; a_vec_mask = m; a_vec_last = last;
    n = 0;
    @(negedge clk);
    while (!a_vec_ready && n < 50) begin @(negedge clk); n++; end
    if (!a_vec_ready) begin
      checks++; errors++;
      $display("FAIL a_accept_timeout: vec_ready=%0b after 50 cycles, required 1", a_vec_ready);
      a_vec_valid = 1'b0; t_acc = $time;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk);
    t_acc = $time;
    f = ref_fail(e, m, d);
    if (f) begin
      if (!m_seen) begin m_seen = 1'b1; m_idx = m_vc; end
      if (m_ec < A_MAX) m_ec++;
    end
    if (m_vc < A_MAX) m_vc++;
    x.mm = f; x.vc = m_vc; x.ec = m_ec; x.seen = m_seen; x.idx = m_idx;
    sb_q.push_back(x);
    #1;
    a_vec_valid = 1'b0; a_vec_last = 1'b0; a_dut_q = d; a_start = poke;
    if (poke) begin @(posedge clk); #1; a_start = 1'b0; end
  endtask

  task automatic finish_run_a();
    int n = 0;
    @(negedge clk);
    while (!a_done && n < 20) begin @(negedge clk); n++; end
    check("a_done", a_done, 1);
    check("a_busy_in_done", a_busy, 0);
    check("a_ready_in_done", a_vec_ready, 0);
    check("a_final_vector_count", a_vector_count, m_vc);
    check("a_final_error_count", a_error_count, m_ec);
    check("a_final_seen", a_first_err_seen, m_seen);
    check("a_final_index", a_first_err_index, m_idx);
    repeat (2) @(negedge clk);
    check("a_done_hold_count", a_vector_count, m_vc);
    check("a_sb_drained", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: each observed handshake is compared on the cycle after its compare.
  initial begin : monitor_a
    exp_t x;
    @(negedge clk);
    forever begin
      if (a_vec_valid && a_vec_ready && !reset) begin
        repeat (AS + 2) @(posedge clk);
        @(negedge clk);
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_sb_empty: compare observed with no expected entry, required one queued");
        end else begin
          x = sb_q.pop_front();
          check("a_mismatch", a_mismatch, x.mm);
          check("a_vector_count", a_vector_count, x.vc);
          check("a_error_count", a_error_count, x.ec);
          check("a_first_err_seen", a_first_err_seen, x.seen);
          check("a_first_err_index", a_first_err_index, x.idx);
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  // mismatch must never stay high two cycles running.
  int mm_pulses = 0;
  bit mm_prev = 1'b0;
  always @(negedge clk) begin
    if (a_mismatch) begin
      checks++;
      if (mm_prev) begin
        errors++;
        $display("FAIL a_mismatch_width: high for 2+ cycles, required 1");
      end else begin
        mm_pulses++;
      end
    end
    mm_prev = a_mismatch;
  end

  task automatic pulse_start_b();
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
  endtask

  task automatic send_b(input logic e, input logic d, input bit last, input bit poke, output time t_acc);
    int n = 0;
    b_vec_valid = 1'b1; b_vec_expected = e; b_vec_mask = 1'b0; b_vec_last = last;
    @(negedge clk);
    while (!b_vec_ready && n < 50) begin @(negedge clk); n++; end
    if (!b_vec_ready) begin
      checks++; errors++;
      $display("FAIL b_accept_timeout: vec_ready=%0b after 50 cycles, required 1", b_vec_ready);
    end
    @(posedge clk);
    t_acc = $time;
    #1;
    b_vec_valid = 1'b0; b_vec_last = 1'b0; b_dut_q = d; b_start = poke;
    if (poke) begin @(posedge clk); #1; b_start = 1'b0; end
  endtask

  task automatic wait_done_b();
    int n = 0;
    @(negedge clk);
    while (!b_done && n < 20) begin @(negedge clk); n++; end
    check("b_done", b_done, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at 200us, required finish");
    $fatal(1, "watchdog expired");
  end

  logic [AW-1:0] seq4 [4];

  initial begin : stimulus
    time         t0, t1;
    int          p0, len;
    logic [AW-1:0] e, m, d;
    t0 = 0; t1 = 0;
    seq4 = '{4'd0, 4'd1, 4'd1, 4'd0};

    // Reset state
    repeat (3) @(negedge clk);
    check("a_rst_vector_count", a_vector_count, 0);
    check("a_rst_error_count", a_error_count, 0);
    check("a_rst_index", a_first_err_index, 0);
    check("a_rst_flags", {a_first_err_seen, a_mismatch, a_busy, a_done, a_vec_ready}, 0);
    check("b_rst_flags", {b_first_err_seen, b_mismatch, b_busy, b_done, b_vec_ready}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset while a vector is offered in WAIT_VEC
    pulse_start_a();
    @(negedge clk);
    check("a_wait_ready", a_vec_ready, 1);
    check("a_wait_busy", a_busy, 1);
    @(posedge clk); #1;
    a_vec_valid = 1'b1; a_vec_expected = 4'hF;
    #2 reset = 1'b1;
    @(negedge clk);
    check("a_midrst_ready", a_vec_ready, 0);
    check("a_midrst_flags", {a_busy, a_done, a_mismatch, a_first_err_seen}, 0);
    @(posedge clk); #1;
    reset = 1'b0; a_vec_valid = 1'b0;
    @(negedge clk);
    check("a_postrst_idle", {a_vec_ready, a_busy, a_done}, 0);
    check("a_postrst_count", a_vector_count, 0);
    @(posedge clk); #1;

    // Matching stream 0,1,1,0: one vector every SETTLE+2 cycles
    pulse_start_a();
    for (int i = 0; i < 4; i++) begin
      send_a(seq4[i], '0, seq4[i], i == 3, 0, 1'b0, t1);
      if (i > 0) check("a_vector_period", t1 - t0, 30);
      t0 = t1;
    end
    finish_run_a();
    check("a_match_vc", a_vector_count, 4);
    check("a_match_ec", a_error_count, 0);

    // Same stream against a stuck-at-0 output
    p0 = mm_pulses;
    pulse_start_a();
    for (int i = 0; i < 4; i++) send_a(seq4[i], '0, '0, i == 3, 0, 1'b0, t1);
    finish_run_a();
    check("a_stuck_ec", a_error_count, 2);
    check("a_stuck_index", a_first_err_index, 1);
    check("a_stuck_pulses", mm_pulses - p0, 2);

    // Masked bits excluded; unmasked same data fails; start while busy ignored
    pulse_start_a();
    send_a(4'b1010, 4'b0011, 4'b1001, 1'b0, 0, 1'b1, t1);
    send_a(4'b1010, 4'b0000, 4'b1001, 1'b1, 1, 1'b0, t1);
    finish_run_a();
    check("a_mask_ec", a_error_count, 1);
    check("a_mask_index", a_first_err_index, 1);

    // Randomized runs, including all-ones and all-zero masks
    for (int r = 0; r < 8; r++) begin
      len = int'($urandom_range(1, 10));
      pulse_start_a();
      for (int i = 0; i < len; i++) begin
        e = AW'($urandom);
        case ($urandom_range(0, 3))
          0: m = '0;
          1: m = '1;
          default: m = AW'($urandom);
        endcase
        d = ($urandom_range(0, 1) == 0) ? e : AW'($urandom);
        send_a(e, m, d, i == len - 1, int'($urandom_range(0, 2)), $urandom_range(0, 7) == 0, t1);
      end
      finish_run_a();
    end

    // B: settle 0, back-to-back vectors, one start pulse while busy
    pulse_start_b();
    for (int i = 0; i < 5; i++) begin
      send_b(1'b1, 1'b1, i == 4, i == 2, t1);
      if (i > 0) check("b_vector_period", t1 - t0, 20);
      t0 = t1;
    end
    wait_done_b();
    check("b_b2b_vc", b_vector_count, 5);
    check("b_b2b_ec", b_error_count, 0);

    // B: ten failing vectors saturate 3-bit counters
    @(posedge clk); #1;
    pulse_start_b();
    for (int i = 0; i < 10; i++) send_b(1'b1, 1'b0, i == 9, 1'b0, t1);
    wait_done_b();
    check("b_sat_vc", b_vector_count, B_MAX);
    check("b_sat_ec", b_error_count, B_MAX);
    check("b_sat_seen", b_first_err_seen, 1);
    check("b_sat_index", b_first_err_index, 0);

    // B: restart from DONE clears the run statistics
    @(posedge clk); #1;
    pulse_start_b();
    @(negedge clk);
    check("b_restart_counts", {b_vector_count, b_error_count, b_first_err_index}, 0);
    check("b_restart_seen", b_first_err_seen, 0);
    check("b_restart_busy", b_busy, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
